// File: rtl/app_ddr_pkg.sv
// Shared constants, command codes and FSM state type for the DDR3 frame address controllers.
package app_ddr_pkg;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  typedef enum logic [1:0] {IDLE, CHECK, ISSUE} rd_state_e;

  // Frame size in controller address units (4 bytes per address unit).
  function automatic int unsigned total_frame_offset(input int unsigned iw,
                                                     input int unsigned ih,
                                                     input int unsigned pix_wd);
    return (iw * ih * pix_wd) / 4;
  endfunction

  // One 256-bit beat spans 8 address units.
  function automatic int unsigned burst_offset(input int unsigned burst_len);
    return burst_len * 8;
  endfunction

  function automatic logic [27:0] last_addr(input logic [27:0] base,
                                            input int unsigned total,
                                            input int unsigned burst);
    return base + 28'(total) - 28'(burst);
  endfunction

endpackage

// File: rtl/app_rd_credit.sv
// Read-data FIFO credit counter: reserves a burst of beats per command, releases one per pop.
module app_rd_credit #(
  parameter int unsigned Depth = 512,
  parameter int unsigned Burst = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic add,
  input  logic sub,
  output logic space_ok
);

  localparam int unsigned CW = $clog2(Depth) + 1;
  localparam logic [CW-1:0] Inc   = CW'(Burst);
  localparam logic [CW-1:0] Limit = CW'(Depth - Burst);

  logic [CW-1:0] credit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_q <= '0;
    end else begin
      credit_q <= credit_q + (add ? Inc : '0) - (sub ? CW'(1) : '0);
    end
  end

  assign space_ok = (credit_q <= Limit);

endmodule

// File: rtl/app_rd_addr_ctrl.sv
// Frame read address controller: credit-metered read bursts over one frame, plus the
// read-data FIFO drain to the downstream consumer.
module app_rd_addr_ctrl
  import app_ddr_pkg::*;
#(
  parameter logic [27:0] rd_base_addr    = 28'h0,
  parameter int unsigned rd_burst_length = 64,
  parameter int unsigned IW              = 1024,
  parameter int unsigned IH              = 768,
  parameter int unsigned Pixel_wd        = 2,
  parameter int unsigned FIFO_DEPTH      = 512
) (
  input  logic         I_clk,
  input  logic         I_Rst_n,
  input  logic         I_rd_en,
  input  logic         I_frame_sync,
  input  logic         rd_cmd_full,
  output logic         rd_cmd_wren,
  output logic [2:0]   rd_cmd_rdcmd,
  output logic [7:0]   rd_cmd_rdbl,
  output logic [27:0]  rd_cmd_rdaddr,
  input  logic         rd_fifo_empty,
  input  logic [255:0] rd_fifo_rdata,
  output logic         rd_fifo_rden,
  input  logic         Post_req,
  output logic [255:0] Post_rdata,
  output logic         Post_rvalid,
  output logic         O_frame_done
);

  localparam int unsigned TotalOff  = total_frame_offset(IW, IH, Pixel_wd);
  localparam int unsigned BurstOff  = burst_offset(rd_burst_length);
  localparam logic [27:0] BurstStep = 28'(BurstOff);
  localparam logic [27:0] LastAddr  = last_addr(rd_base_addr, TotalOff, BurstOff);

  if ((TotalOff % BurstOff) != 0) begin : g_frame_chk
    $error("frame size is not a whole number of read bursts");
  end
  if (FIFO_DEPTH < rd_burst_length) begin : g_depth_chk
    $error("read-data FIFO cannot hold one burst");
  end

  rd_state_e state_q;
  logic      sync_pend_q;
  logic      space_ok;

  assign rd_cmd_rdcmd = CMD_RD;
  assign rd_cmd_rdbl  = 8'(rd_burst_length);
  assign rd_fifo_rden = Post_req & ~rd_fifo_empty;

  app_rd_credit #(
    .Depth (FIFO_DEPTH),
    .Burst (rd_burst_length)
  ) u_credit (
    .clk      (I_clk),
    .rst_n    (I_Rst_n),
    .add      (rd_cmd_wren),
    .sub      (rd_fifo_rden),
    .space_ok (space_ok)
  );

  always_ff @(posedge I_clk or negedge I_Rst_n) begin
    if (!I_Rst_n) begin
      state_q       <= IDLE;
      rd_cmd_wren   <= 1'b0;
      rd_cmd_rdaddr <= rd_base_addr;
      sync_pend_q   <= 1'b0;
      O_frame_done  <= 1'b0;
    end else begin
      rd_cmd_wren  <= 1'b0;
      O_frame_done <= 1'b0;
      if (I_frame_sync) sync_pend_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (I_rd_en) state_q <= CHECK;
        end
        CHECK: begin
          if (!I_rd_en) begin
            state_q <= IDLE;
          end else if (space_ok && !rd_cmd_full) begin
            state_q     <= ISSUE;
            rd_cmd_wren <= 1'b1;
          end
        end
        ISSUE: begin
          state_q <= CHECK;
          if (rd_cmd_rdaddr == LastAddr) O_frame_done <= 1'b1;
          // A pending sync overrides the walk; a sync arriving now stays pending.
          if (sync_pend_q) begin
            rd_cmd_rdaddr <= rd_base_addr;
            sync_pend_q   <= I_frame_sync;
          end else if (rd_cmd_rdaddr == LastAddr) begin
            rd_cmd_rdaddr <= rd_base_addr;
          end else begin
            rd_cmd_rdaddr <= rd_cmd_rdaddr + BurstStep;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge I_clk or negedge I_Rst_n) begin
    if (!I_Rst_n) begin
      Post_rvalid <= 1'b0;
      Post_rdata  <= '0;
    end else begin
      Post_rvalid <= rd_fifo_rden;
      if (Post_rvalid) Post_rdata <= rd_fifo_rdata;
    end
  end

endmodule

// File: tb/tb_app_rd_addr_ctrl.sv
// Directed, table-driven bench for app_rd_addr_ctrl on a 2-burst frame at base 0x100.
module tb_app_rd_addr_ctrl;

  localparam logic [27:0] Base = 28'h100;
  localparam int          Bl   = 2;

  logic         I_clk = 1'b0;
  logic         I_Rst_n = 1'b0;
  logic         I_rd_en = 1'b0;
  logic         I_frame_sync = 1'b0;
  logic         rd_cmd_full = 1'b0;
  logic         rd_cmd_wren;
  logic [2:0]   rd_cmd_rdcmd;
  logic [7:0]   rd_cmd_rdbl;
  logic [27:0]  rd_cmd_rdaddr;
  logic         rd_fifo_empty;
  logic [255:0] rd_fifo_rdata;
  logic         rd_fifo_rden;
  logic         Post_req = 1'b0;
  logic [255:0] Post_rdata;
  logic         Post_rvalid;
  logic         O_frame_done;

  int n_chk = 0;
  int n_fail = 0;

  // Mock read-data FIFO: a command's beats land at once; empty either modelled or forced.
  bit           use_model = 1'b0;
  logic         empty_drv = 1'b1;
  logic [255:0] rdata_drv = '0;
  int           fifo_cnt;

  assign rd_fifo_empty = use_model ? (fifo_cnt == 0) : empty_drv;
  assign rd_fifo_rdata = rdata_drv;

  always @(posedge I_clk or negedge I_Rst_n) begin
    if (!I_Rst_n) fifo_cnt <= 0;
    else fifo_cnt <= fifo_cnt + (rd_cmd_wren ? Bl : 0) - (rd_fifo_rden ? 1 : 0);
  end

  always #5 I_clk = ~I_clk;

  app_rd_addr_ctrl #(
    .rd_base_addr    (Base),
    .rd_burst_length (2),
    .IW              (16),
    .IH              (4),
    .Pixel_wd        (2),
    .FIFO_DEPTH      (4)
  ) dut (
    .I_clk         (I_clk),
    .I_Rst_n       (I_Rst_n),
    .I_rd_en       (I_rd_en),
    .I_frame_sync  (I_frame_sync),
    .rd_cmd_full   (rd_cmd_full),
    .rd_cmd_wren   (rd_cmd_wren),
    .rd_cmd_rdcmd  (rd_cmd_rdcmd),
    .rd_cmd_rdbl   (rd_cmd_rdbl),
    .rd_cmd_rdaddr (rd_cmd_rdaddr),
    .rd_fifo_empty (rd_fifo_empty),
    .rd_fifo_rdata (rd_fifo_rdata),
    .rd_fifo_rden  (rd_fifo_rden),
    .Post_req      (Post_req),
    .Post_rdata    (Post_rdata),
    .Post_rvalid   (Post_rvalid),
    .O_frame_done  (O_frame_done)
  );

  typedef struct {
    logic         req;
    logic         empty;
    logic [255:0] rdata;
    logic         exp_rden;
    logic [255:0] exp_post;
  } dp_vec_t;

  typedef struct {
    bit          sync;
    logic [27:0] addr;
    logic        done;
  } cmd_vec_t;

  dp_vec_t  dvec[5];
  cmd_vec_t cvec[9];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    I_Rst_n = 1'b0;
    I_rd_en = 1'b0;
    I_frame_sync = 1'b0;
    rd_cmd_full = 1'b0;
    Post_req = 1'b0;
    repeat (2) @(negedge I_clk);
    I_Rst_n = 1'b1;
  endtask

  // Waits (bounded) for the next command; returns its address and the following-cycle done.
  task automatic next_cmd(output logic [27:0] a, output logic done);
    bit ok = 1'b0;
    a = '0;
    done = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge I_clk);
      if (rd_cmd_wren) begin
        ok = 1'b1;
        a = rd_cmd_rdaddr;
        chk("rdcmd", 256'(rd_cmd_rdcmd), 256'(3'b001));
        chk("rdbl", 256'(rd_cmd_rdbl), 256'(8'd2));
      end
    end
    chk("cmd issued in time", 256'(ok), 256'(1));
    if (ok) begin
      @(negedge I_clk);
      done = O_frame_done;
    end
  endtask

  task automatic run_count(input int n, output int c);
    c = 0;
    repeat (n) begin
      @(negedge I_clk);
      if (rd_cmd_wren) c++;
    end
  endtask

  initial begin
    logic [27:0] a;
    logic        d;
    int          c;
    bit          seen;

    dvec[0] = '{1'b1, 1'b0, {8{32'hA5A5A5A5}}, 1'b1, {8{32'hA5A5A5A5}}};
    dvec[1] = '{1'b1, 1'b1, {8{32'h5A5A5A5A}}, 1'b0, {8{32'hA5A5A5A5}}};
    dvec[2] = '{1'b0, 1'b0, {8{32'h3C3C3C3C}}, 1'b0, {8{32'hA5A5A5A5}}};
    dvec[3] = '{1'b1, 1'b0, {8{32'hC3C3C3C3}}, 1'b1, {8{32'hC3C3C3C3}}};
    dvec[4] = '{1'b0, 1'b1, {8{32'h00000000}}, 1'b0, {8{32'hC3C3C3C3}}};

    cvec[0] = '{1'b0, 28'h100, 1'b0};
    cvec[1] = '{1'b0, 28'h110, 1'b1};
    cvec[2] = '{1'b0, 28'h100, 1'b0};
    cvec[3] = '{1'b0, 28'h110, 1'b1};
    cvec[4] = '{1'b1, 28'h100, 1'b0};
    cvec[5] = '{1'b0, 28'h100, 1'b0};
    cvec[6] = '{1'b1, 28'h110, 1'b1};
    cvec[7] = '{1'b0, 28'h100, 1'b0};
    cvec[8] = '{1'b0, 28'h110, 1'b1};

    // Reset state
    do_reset();
    @(negedge I_clk);
    chk("reset wren", 256'(rd_cmd_wren), 256'(0));
    chk("reset addr", 256'(rd_cmd_rdaddr), 256'(Base));
    chk("reset rvalid", 256'(Post_rvalid), 256'(0));
    chk("reset rdata", Post_rdata, 256'(0));
    chk("reset frame_done", 256'(O_frame_done), 256'(0));
    chk("rdcmd const", 256'(rd_cmd_rdcmd), 256'(3'b001));
    chk("rdbl const", 256'(rd_cmd_rdbl), 256'(8'd2));

    // Data path vectors (commands disabled, FIFO flags forced)
    use_model = 1'b0;
    for (int i = 0; i < 5; i++) begin
      Post_req  = dvec[i].req;
      empty_drv = dvec[i].empty;
      rdata_drv = dvec[i].rdata;
      #1;
      chk($sformatf("rden vec%0d", i), 256'(rd_fifo_rden), 256'(dvec[i].exp_rden));
      @(negedge I_clk);
      Post_req = 1'b0;
      chk($sformatf("rvalid vec%0d", i), 256'(Post_rvalid), 256'(dvec[i].exp_rden));
      @(negedge I_clk);
      chk($sformatf("rdata vec%0d", i), Post_rdata, dvec[i].exp_post);
      chk($sformatf("rvalid drop vec%0d", i), 256'(Post_rvalid), 256'(0));
    end

    // Streaming with frame wraps and frame syncs at both addresses
    use_model = 1'b1;
    do_reset();
    I_rd_en  = 1'b1;
    Post_req = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (cvec[i].sync) begin
        I_frame_sync = 1'b1;
        @(posedge I_clk);
        #1 I_frame_sync = 1'b0;
      end
      next_cmd(a, d);
      chk($sformatf("cmd%0d addr", i), 256'(a), 256'(cvec[i].addr));
      chk($sformatf("cmd%0d frame_done", i), 256'(d), 256'(cvec[i].done));
    end

    // Credit stall: no pops, FIFO depth 4 holds exactly two bursts
    do_reset();
    I_rd_en = 1'b1;
    run_count(30, c);
    chk("cmds before stall", 256'(c), 256'(2));
    Post_req = 1'b1;
    @(negedge I_clk);
    Post_req = 1'b0;
    run_count(10, c);
    chk("stalled after 1 pop", 256'(c), 256'(0));
    Post_req = 1'b1;
    @(negedge I_clk);
    Post_req = 1'b0;
    run_count(10, c);
    chk("issued after 2 pops", 256'(c), 256'(1));

    // Command FIFO full back-pressure
    do_reset();
    rd_cmd_full = 1'b1;
    I_rd_en = 1'b1;
    Post_req = 1'b1;
    run_count(10, c);
    chk("no cmd while full", 256'(c), 256'(0));
    rd_cmd_full = 1'b0;
    run_count(2, c);
    chk("cmd after full release", 256'(c), 256'(1));

    // Asynchronous reset in the middle of the second ISSUE
    do_reset();
    I_rd_en = 1'b1;
    Post_req = 1'b1;
    next_cmd(a, d);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge I_clk);
      if (rd_cmd_wren) seen = 1'b1;
    end
    chk("second issue seen", 256'(seen), 256'(1));
    chk("second issue addr", 256'(rd_cmd_rdaddr), 256'(28'h110));
    #2 I_Rst_n = 1'b0;
    #1;
    chk("async rst wren", 256'(rd_cmd_wren), 256'(0));
    chk("async rst addr", 256'(rd_cmd_rdaddr), 256'(Base));
    chk("async rst credit", 256'(dut.u_credit.credit_q), 256'(0));
    chk("async rst rvalid", 256'(Post_rvalid), 256'(0));
    chk("async rst frame_done", 256'(O_frame_done), 256'(0));
    Post_req = 1'b0;
    I_rd_en = 1'b0;
    repeat (2) @(negedge I_clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
